// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, FIFO/timeout defaults and the drain FSM encoding.
package uart_pkg;

    localparam int BYTE_W              = 8;
    localparam int DEFAULT_DEPTH       = 16;
    localparam int DEFAULT_ACK_TIMEOUT = 4095;

    typedef logic [BYTE_W-1:0] byte_t;

    // Drain FSM encoding, kept as plain constants so older blocks can share it
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_STROBE    = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 byte storage with one write port and a registered, enable-gated read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  byte_t         wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output byte_t         rd_data
);

    byte_t mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register only loads on a pop, so it doubles as the held tx byte
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: queues writes and drains them one frame at a time.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [BYTE_W-1:0]      wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   tx_busy,
    output logic                   tx_en,
    output logic [BYTE_W-1:0]      tx_data,
    output logic                   overflow,
    output logic                   ack_err,
    input  logic                   clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [TW-1:0] to_cnt;
    logic          pop;
    logic          push;
    logic          drop;
    logic          timeout;

    assign pop     = (state == ST_IDLE) && !empty && !tx_busy;
    assign push    = wr_en && (!full || pop);
    assign drop    = wr_en && full && !pop;
    assign timeout = (state == ST_WAIT_ACK) && !tx_busy && (to_cnt == TW'(ACK_TIMEOUT - 1));
    assign tx_en   = (state == ST_STROBE);

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .sys_clk (sys_clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (tx_data)
    );

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // full/empty are registered from the next occupancy so they line up with count
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (pop) state_next = ST_STROBE;
            ST_STROBE:    state_next = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (tx_busy) state_next = ST_WAIT_DONE;
                          else if (timeout) state_next = ST_IDLE;
            ST_WAIT_DONE: if (!tx_busy) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            to_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_STROBE || timeout) begin
                to_cnt <= '0;
            end else if (state == ST_WAIT_ACK && !tx_busy) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Sticky error flags; a new set event in the same cycle beats clr_err
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (timeout) begin
                ack_err <= 1'b1;
            end else if (clr_err) begin
                ack_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed-plus-random bench for uart_tx_fifo with a behavioural UART responder and byte scoreboard.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int TO    = 24;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b0;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       tx_busy;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       overflow;
    logic       ack_err;
    logic       clr_err;

    logic       uart_busy;
    logic       force_busy;
    bit         uart_ack;
    int         rise_dly;
    int         busy_len;
    int         txen_total = 0;
    int         checks     = 0;
    int         errors     = 0;
    int         model_occ;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    assign tx_busy = uart_busy | force_busy;

    always #5 sys_clk = ~sys_clk;

    uart_tx_fifo #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (TO)
    ) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_busy  (tx_busy),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .overflow (overflow),
        .ack_err  (ack_err),
        .clr_err  (clr_err)
    );

    // UART model: records every strobed byte, then raises busy rise_dly cycles later for busy_len cycles
    initial begin
        int phase;
        int left;
        phase     = 0;
        left      = 0;
        uart_busy = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (rst) begin
                uart_busy = 1'b0;
                phase     = 0;
            end else if (tx_en) begin
                rx_q.push_back(tx_data);
                txen_total++;
                if (uart_ack) begin
                    phase = 1;
                    left  = rise_dly;
                end
            end else if (phase == 1) begin
                left--;
                if (left == 0) begin
                    uart_busy = 1'b1;
                    phase     = 2;
                    left      = busy_len;
                end
            end else if (phase == 2) begin
                left--;
                if (left == 0) begin
                    uart_busy = 1'b0;
                    phase     = 0;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Queue model used only while the UART is held busy, so nothing drains
    task automatic push_model(input logic [7:0] d);
        if (model_occ < DEPTH) begin
            exp_q.push_back(d);
            model_occ++;
        end
        push(d);
    endtask

    task automatic drain(input int target, input string tag);
        int n;
        n = 0;
        while (txen_total < target && n < 2000) begin
            tick();
            n++;
        end
        chk({tag, "_txen_total"}, txen_total, target);
        n = 0;
        while ((uart_busy || !empty) && n < 200) begin
            tick();
            n++;
        end
        tick(3);
        chk({tag, "_empty"}, empty, 1'b1);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_len"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"},    count,    0);
        chk({tag, "_empty"},    empty,    1);
        chk({tag, "_full"},     full,     0);
        chk({tag, "_tx_en"},    tx_en,    0);
        chk({tag, "_tx_data"},  tx_data,  0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_ack_err"},  ack_err,  0);
    endtask

    initial begin
        int         base;
        int         bad;
        int         n;
        logic [7:0] x;
        logic [7:0] y;

        wr_en      = 1'b0;
        wr_data    = 8'h00;
        clr_err    = 1'b0;
        force_busy = 1'b0;
        uart_ack   = 1'b1;
        rise_dly   = 3;
        busy_len   = 20;
        model_occ  = 0;
        #1 rst = 1'b1;
        tick(3);
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Single byte: one strobe two edges after the write, byte held through the frame
        push(8'hA5);
        chk("a5_no_early_txen", tx_en, 0);
        chk("a5_count1", count, 1);
        tick();
        chk("a5_txen", tx_en, 1);
        chk("a5_txdata", tx_data, 8'hA5);
        chk("a5_count0", count, 0);
        bad = 0;
        repeat (24) begin
            tick();
            if (tx_data !== 8'hA5) bad++;
        end
        chk("a5_hold", bad, 0);
        tick(5);
        chk("a5_one_pulse", txen_total, 1);
        chk("a5_empty", empty, 1);
        exp_q.push_back(8'hA5);
        check_rx("a5");

        // Fill to full with the UART busy, then overflow the FIFO
        force_busy = 1'b1;
        rise_dly   = 2;
        busy_len   = 4;
        model_occ  = 0;
        for (int i = 0; i < 16; i++) push_model(8'(i));
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        push_model(8'($urandom));
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 16);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Write while full in the same cycle as a pop
        force_busy = 1'b0;
        wr_en      = 1'b1;
        wr_data    = 8'h3C;
        tick();
        wr_en      = 1'b0;
        exp_q.push_back(8'h3C);
        chk("popwr_count", count, 16);
        chk("popwr_full", full, 1);
        chk("popwr_ovf", overflow, 0);
        drain(1 + 17, "order");
        check_rx("order");

        // clr_err and a dropped write together: set wins
        force_busy = 1'b1;
        model_occ  = 0;
        for (int i = 0; i < 16; i++) push_model(8'($urandom));
        clr_err = 1'b1;
        push_model(8'($urandom));
        clr_err = 1'b0;
        chk("setwins_ovf", overflow, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_alone_ovf", overflow, 0);
        base       = txen_total;
        force_busy = 1'b0;
        drain(base + 16, "rand");
        check_rx("rand");

        // Acknowledge timeout: first byte is dropped after TO cycles, second is strobed normally
        uart_ack = 1'b0;
        base     = txen_total;
        x        = 8'($urandom);
        y        = 8'($urandom);
        push(x);
        push(y);
        n = 0;
        while (!tx_en && n < 10) begin
            tick();
            n++;
        end
        chk("to_first_txen", tx_en, 1);
        tick(TO);
        chk("to_not_yet", ack_err, 0);
        tick();
        chk("to_ack_err", ack_err, 1);
        chk("to_idle_no_txen", tx_en, 0);
        uart_ack = 1'b1;
        tick();
        chk("to_next_txen", tx_en, 1);
        chk("to_next_data", tx_data, y);
        exp_q.push_back(x);
        exp_q.push_back(y);
        drain(base + 2, "to");
        chk("to_sticky", ack_err, 1);
        check_rx("to");
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_clr", ack_err, 0);

        // Reset during WAIT_DONE with five bytes still queued
        rise_dly = 1;
        busy_len = 30;
        base     = txen_total;
        x        = 8'($urandom);
        push(x);
        for (int i = 0; i < 5; i++) push(8'($urandom));
        tick(2);
        chk("rst_pre_count", count, 5);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        tick(2);
        rst = 1'b0;
        tick(40);
        chk("midrst_no_txen", txen_total, base + 1);
        exp_q.push_back(x);
        check_rx("midrst");
        y = 8'($urandom);
        push(y);
        exp_q.push_back(y);
        drain(base + 2, "post_rst");
        check_rx("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16: FIFO depth in bytes; a power of two, 4..256.
REQ-002 Parameter ACK_TIMEOUT, default 4095: maximum sys_clk cycles to wait for tx_busy to rise after a tx_en strobe.
REQ-003 sys_clk  in  1: the single clock; all state changes on its rising edge.
REQ-004 rst  in  1: reset, asynchronous and active-high.
REQ-005 wr_en  in  1: write strobe; wr_data is pushed in any cycle wr_en=1 and the write is accepted.
REQ-006 wr_data  in  8: byte to enqueue.
REQ-007 full  out  1: FIFO holds DEPTH bytes.
REQ-008 empty  out  1: FIFO holds 0 bytes.
REQ-009 count  out  clog2(DEPTH)+1: current occupancy.
REQ-010 tx_busy  in  1: from uart; 1 while a frame is being shifted out.
REQ-011 tx_en  out  1: one-cycle start strobe to uart.
REQ-012 tx_data  out  8: byte to uart; held stable from the tx_en cycle until the FSM returns to IDLE.
REQ-013 overflow  out  1: sticky; a write was dropped.
REQ-014 ack_err  out  1: sticky; ACK_TIMEOUT expired.
REQ-015 clr_err  in  1: synchronous clear of overflow and ack_err.

Function
REQ-016 Storage SHALL be a DEPTH x 8 circular buffer with wrapping read/write pointers; full/empty/count SHALL be registered and derived from the occupancy counter.
REQ-017 A write SHALL be accepted when full=0, or when full=1 and a pop occurs in the same cycle; otherwise the write is dropped and overflow is set.
REQ-018 A simultaneous push and pop SHALL leave count unchanged, and both pointers SHALL advance.
REQ-019 Drain FSM states SHALL be IDLE, STROBE, WAIT_ACK and WAIT_DONE.
REQ-020 In IDLE with empty=0 and tx_busy=0: pop the head byte into tx_data, then go to STROBE (the pop is visible in count on the next cycle).
REQ-021 In STROBE: drive tx_en=1 for exactly this one cycle, clear the timeout counter, then go to WAIT_ACK.
REQ-022 In WAIT_ACK: go to WAIT_DONE on tx_busy=1; otherwise increment the counter.
REQ-023 In WAIT_ACK, when the counter reaches ACK_TIMEOUT: set ack_err and go to IDLE; the byte counts as consumed and is not retried.
REQ-024 In WAIT_DONE: go to IDLE on tx_busy=0.
REQ-025 Minimum spacing between tx_en strobes SHALL be 4 cycles; tx_en SHALL never be asserted outside STROBE.
REQ-026 If clr_err and a set condition occur in the same cycle, set SHALL win.
REQ-027 A write to an empty FIFO SHALL produce tx_en no earlier than 2 cycles after the write edge (write, IDLE pop, STROBE).

Reset
REQ-028 While rst=1: pointers and count = 0, empty=1, full=0, FSM in IDLE, tx_en=0, tx_data=8'h00, overflow=0, ack_err=0, timeout counter = 0.
REQ-029 Reset mid-frame SHALL discard all queued bytes and the byte in flight; no tx_en is issued until rst deasserts and new data is written.
REQ-030 Deassertion of rst is assumed synchronised externally; the first legal write is in the cycle after deassertion.

Structure
REQ-031 DEPTH and ACK_TIMEOUT defaults, the FSM state encoding (2-bit localparams) and the byte width SHALL live in a shared uart package also used by uart.
REQ-032 One sub-module is natural: uart_fifo_mem (DEPTH x 8 storage with registered read); the FSM, pointers and flags stay in uart_tx_fifo.

Verification
REQ-033 Push 8'hA5 to an empty FIFO with tx_busy modelled to rise 3 cycles after tx_en and stay high 20 cycles -> exactly one tx_en pulse, tx_data=8'hA5 until IDLE, empty=1 afterwards.
REQ-034 Push 16 bytes 0x00..0x0F back-to-back with the uart busy -> full=1 and count=16 at peak; the uart receives the bytes in order 0x00..0x0F; a 17th push while full sets overflow and that byte is never sent.
REQ-035 With full=1 and a pop in progress, push 8'h3C in the pop cycle -> the write is accepted, count stays 16, overflow remains 0.
REQ-036 tx_busy held at 0 with one byte queued -> ack_err=1 exactly ACK_TIMEOUT cycles after WAIT_ACK entry; FSM back in IDLE; the next queued byte is then strobed normally.
REQ-037 Assert rst during WAIT_DONE with 5 bytes queued -> all outputs immediately at reset values; after release, no tx_en until a new write.
REQ-038 Assert clr_err in the same cycle as a dropped write -> overflow=1 (set wins); clr_err alone the next cycle -> overflow=0.
